// File: rtl/io_periph_ctrl_if.sv
// Core-side I/O bus between the MIPS I/O port and the peripheral block.
// Reads are combinational; writes land on the clock edge with IOWriteEn high.
interface io_periph_ctrl_if;
    logic [31:0] IOWriteData;
    logic [3:0]  IOAddr;
    logic        IOWriteEn;
    logic [31:0] IOReadData;

    modport master (
        output IOWriteData,
        output IOAddr,
        output IOWriteEn,
        input  IOReadData
    );

    modport slave (
        input  IOWriteData,
        input  IOAddr,
        input  IOWriteEn,
        output IOReadData
    );
endinterface

// File: rtl/io_periph_ctrl.sv
// Memory-mapped I/O peripheral: LED/display registers, game-tick timer,
// sticky button events, cycle counter and LFSR random source.
module io_periph_ctrl #(
    parameter int          NUM_BTN     = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] LFSR_SEED   = 32'hACE12468
) (
    input  logic               CLK,
    input  logic               RESET,
    io_periph_ctrl_if.slave    bus,
    input  logic [NUM_BTN-1:0] BTN,
    output logic [7:0]         LED,
    output logic [31:0]        DISP
);

    localparam logic [31:0] LFSR_MASK = 32'h80200003;

    logic [31:0] tper, cnt, cyc, lfsr;
    logic        tick, ten;
    logic [NUM_BTN-1:0] sync [SYNC_STAGES];
    logic [NUM_BTN-1:0] prev, armed, btnev;
    logic [NUM_BTN-1:0] btn_lvl, btn_rise, btn_clr;
    logic [SYNC_STAGES-1:0] vld;
    logic        sel_led, sel_disp, sel_tper, sel_tstat, sel_btn, sel_rand;
    logic        tick_hit, run;
    logic [31:0] btn_word;

    always_comb begin
        sel_led   = bus.IOWriteEn && (bus.IOAddr == 4'h0);
        sel_disp  = bus.IOWriteEn && (bus.IOAddr == 4'h1);
        sel_tper  = bus.IOWriteEn && (bus.IOAddr == 4'h2);
        sel_tstat = bus.IOWriteEn && (bus.IOAddr == 4'h3);
        sel_btn   = bus.IOWriteEn && (bus.IOAddr == 4'h4);
        sel_rand  = bus.IOWriteEn && (bus.IOAddr == 4'h6);
    end

    assign run      = ten && (tper != 32'd0);
    assign tick_hit = run && (cnt == tper - 32'd1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LED  <= '0;
            DISP <= '0;
            tper <= '0;
            cnt  <= '0;
            tick <= 1'b0;
            ten  <= 1'b0;
            cyc  <= '0;
            lfsr <= LFSR_SEED;
        end else begin
            if (sel_led)  LED  <= bus.IOWriteData[7:0];
            if (sel_disp) DISP <= bus.IOWriteData;
            if (sel_tper) begin
                tper <= bus.IOWriteData;
                cnt  <= '0;
            end else if (run) begin
                cnt <= tick_hit ? 32'd0 : cnt + 32'd1;
            end
            if (sel_tstat) ten <= bus.IOWriteData[1];
            // Set beats a same-cycle W1C so a tick is never lost.
            tick <= tick_hit | (tick & ~(sel_tstat & bus.IOWriteData[0]));
            cyc  <= cyc + 32'd1;
            if (sel_rand)
                lfsr <= (bus.IOWriteData != 32'd0) ? bus.IOWriteData : LFSR_SEED;
            else
                lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
        end
    end

    assign btn_lvl  = sync[SYNC_STAGES-1];
    assign btn_rise = btn_lvl & ~prev & armed;
    assign btn_clr  = sel_btn ? bus.IOWriteData[NUM_BTN-1:0] : '0;

    // A button only arms after a genuine released sample following reset,
    // so a button held through reset release yields no event.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
            prev  <= '0;
            armed <= '0;
            btnev <= '0;
            vld   <= '0;
        end else begin
            sync[0] <= BTN;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            prev  <= btn_lvl;
            vld   <= {vld[SYNC_STAGES-2:0], 1'b1};
            armed <= armed | (~btn_lvl & {NUM_BTN{vld[SYNC_STAGES-1]}});
            btnev <= btn_rise | (btnev & ~btn_clr);
        end
    end

    always_comb begin
        btn_word = '0;
        btn_word[NUM_BTN-1:0]  = btnev;
        btn_word[16 +: NUM_BTN] = btn_lvl;
    end

    always_comb begin
        bus.IOReadData = '0;
        case (bus.IOAddr)
            4'h0: bus.IOReadData = {24'd0, LED};
            4'h1: bus.IOReadData = DISP;
            4'h2: bus.IOReadData = tper;
            4'h3: bus.IOReadData = {30'd0, ten, tick};
            4'h4: bus.IOReadData = btn_word;
            4'h5: bus.IOReadData = cyc;
            4'h6: bus.IOReadData = lfsr;
            default: bus.IOReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_io_periph_ctrl.sv
// Directed bench for io_periph_ctrl: reads are queued with their expected
// values and popped for comparison once the combinational read settles.
module tb_io_periph_ctrl;

    localparam logic [31:0] SEED = 32'hACE12468;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  BTN;
    logic [7:0]  LED;
    logic [31:0] DISP;

    io_periph_ctrl_if bus();

    io_periph_ctrl #(
        .NUM_BTN(4),
        .SYNC_STAGES(2),
        .LFSR_SEED(SEED)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus),
        .BTN(BTN),
        .LED(LED),
        .DISP(DISP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int unsigned cyc_m = 0;

    always @(posedge CLK) begin
        if (RESET) cyc_m <= 0;
        else       cyc_m <= cyc_m + 1;
    end

    function automatic logic [31:0] step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] a,
                      input logic [31:0] e);
        exp_t x;
        bus.IOAddr = a;
        sb.push_back('{tag, e});
        #1;
        x = sb.pop_front();
        check(x.tag, bus.IOReadData, x.exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.IOAddr      = a;
        bus.IOWriteData = d;
        bus.IOWriteEn   = 1'b1;
        @(posedge CLK);
        #1;
        bus.IOWriteEn   = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        RESET           = 1'b1;
        BTN             = '0;
        bus.IOAddr      = '0;
        bus.IOWriteData = '0;
        bus.IOWriteEn   = 1'b0;
        #2;
        for (int a = 0; a < 16; a++)
            rd($sformatf("rst_rd%0d", a), a[3:0], (a == 6) ? SEED : 32'd0);
        check("rst_led", {24'd0, LED}, 32'd0);
        check("rst_disp", DISP, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        tick(2);

        wr(4'h0, 32'h000001A5);
        wr(4'h1, 32'hDEADBEEF);
        check("led", {24'd0, LED}, 32'h000000A5);
        check("disp", DISP, 32'hDEADBEEF);
        rd("rd_led", 4'h0, 32'h000000A5);
        rd("rd_disp", 4'h1, 32'hDEADBEEF);

        wr(4'h2, 32'd4);
        wr(4'h3, 32'd2);
        rd("ten_on", 4'h3, 32'd2);
        tick(3);
        rd("pre_tick", 4'h3, 32'd2);
        wr(4'h3, 32'd3);
        rd("set_wins", 4'h3, 32'd3);
        wr(4'h3, 32'd3);
        rd("tick_clr", 4'h3, 32'd2);
        tick(2);
        rd("tick_wait", 4'h3, 32'd2);
        tick(1);
        rd("tick_again", 4'h3, 32'd3);
        wr(4'h3, 32'd1);
        rd("ten_off", 4'h3, 32'd0);
        tick(6);
        rd("held_off", 4'h3, 32'd0);

        wr(4'h2, 32'd1);
        wr(4'h3, 32'd2);
        rd("p1_en", 4'h3, 32'd2);
        tick(1);
        rd("p1_tick", 4'h3, 32'd3);
        wr(4'h3, 32'd2);
        rd("w1c_zero", 4'h3, 32'd3);
        wr(4'h3, 32'd0);
        rd("p1_dis", 4'h3, 32'd1);
        wr(4'h3, 32'd1);
        rd("p1_clr", 4'h3, 32'd0);

        wr(4'h2, 32'd0);
        wr(4'h3, 32'd2);
        tick(8);
        rd("p0_none", 4'h3, 32'd2);
        wr(4'h3, 32'd0);

        BTN = 4'b0100;
        tick(2);
        rd("btn_lvl", 4'h4, 32'h00040000);
        tick(1);
        rd("btn_ev", 4'h4, 32'h00040004);
        tick(20);
        rd("btn_hold", 4'h4, 32'h00040004);
        wr(4'h4, 32'd4);
        rd("btn_w1c", 4'h4, 32'h00040000);
        tick(5);
        rd("btn_once", 4'h4, 32'h00040000);
        BTN = 4'b0000;
        tick(4);
        rd("btn_rel", 4'h4, 32'd0);
        BTN = 4'b0001;
        tick(2);
        wr(4'h4, 32'd1);
        rd("btn_setwin", 4'h4, 32'h00010001);
        wr(4'h4, 32'd1);
        rd("btn_clr0", 4'h4, 32'h00010000);
        BTN = 4'b0000;
        tick(4);

        wr(4'h6, 32'd0);
        rd("rand_seed", 4'h6, SEED);
        tick(1);
        rd("rand_step", 4'h6, step(SEED));
        wr(4'h6, 32'd1);
        rd("rand_one", 4'h6, 32'd1);
        tick(1);
        rd("rand_s1", 4'h6, 32'h80200003);
        tick(1);
        rd("rand_s2", 4'h6, 32'hC0300002);

        rd("cyc_a", 4'h5, cyc_m);
        r = cyc_m + 10;
        tick(10);
        rd("cyc_b", 4'h5, r);
        wr(4'h5, 32'h12345678);
        rd("cyc_ro", 4'h5, cyc_m);
        wr(4'h9, 32'hFFFFFFFF);
        rd("hole_rd", 4'h9, 32'd0);

        wr(4'h2, 32'd100);
        wr(4'h3, 32'd2);
        BTN = 4'b0010;
        tick(5);
        RESET = 1'b1;
        #1;
        rd("rst_tstat", 4'h3, 32'd0);
        rd("rst_cyc", 4'h5, 32'd0);
        rd("rst_tper", 4'h2, 32'd0);
        rd("rst_btn", 4'h4, 32'd0);
        rd("rst_rand", 4'h6, SEED);
        check("rst_led2", {24'd0, LED}, 32'd0);
        tick(2);
        RESET = 1'b0;
        tick(6);
        rd("held_rst", 4'h4, 32'h00020000);
        BTN = 4'b0000;
        tick(4);
        rd("held_rel", 4'h4, 32'd0);
        BTN = 4'b0010;
        tick(3);
        rd("held_new", 4'h4, 32'h00020002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
